dmem_responder: RTL

- Word-addressed data-memory responder: the memory end of the CPU load/store path.
- Accepts one request at a time, consisting of a word address, byte enables, write data and a read/write flag.
- Applies a programmable number of wait states, commits byte-masked writes or returns the full 32-bit word, and signals completion with a one-cycle ready pulse.
- The CPU side selects the byte lanes and performs sign extension; this block only stores and returns whole words under lane masks.

---
 rtl/dmem_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder: wait-state FSM in front of four byte-lane RAMs.
// Optional DMEM_FAULT_EN adds an err output that flags addresses above the storage range.
module dmem_lane #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic                  wr_en,
    input  logic [7:0]            wr_byte,
    input  logic                  rd_en,
    input  logic                  rd_zero,
    output logic [7:0]            rd_byte
);
    logic [7:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk)
        if (wr_en) mem[idx] <= wr_byte;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)     rd_byte <= '0;
        else if (rd_en) rd_byte <= rd_zero ? 8'h00 : mem[idx];
endmodule

module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [29:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy
`ifdef DMEM_FAULT_EN
    ,
    output logic        err
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    state_t     state, state_nx;
    logic [3:0] cnt;
    req_t       live, rq, cur;
    logic       commit, fault;

    assign live = '{we: we, addr: addr, be: be, wdata: wdata};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd1) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rq    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                rq  <= live;
                cnt <= WC;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Storage acts on the edge entering RESP; with zero wait states that edge is the
    // acceptance edge itself, so the live request fields are used instead of the latch.
    assign commit = (state_nx == RESP) && (state != RESP);
    assign cur    = (state == IDLE) ? live : rq;

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);

`ifdef DMEM_FAULT_EN
    assign fault = |cur.addr[29:DEPTH_LOG2];
    assign err   = ready && (|rq.addr[29:DEPTH_LOG2]);
`else
    logic unused_hi;
    assign fault     = 1'b0;
    assign unused_hi = ^cur.addr[29:DEPTH_LOG2];
`endif

    for (genvar i = 0; i < 4; i++) begin : g_lane
        dmem_lane #(.DEPTH_LOG2(DEPTH_LOG2)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .idx     (cur.addr[DEPTH_LOG2-1:0]),
            .wr_en   (commit & cur.we & cur.be[i] & ~fault),
            .wr_byte (cur.wdata[8*i +: 8]),
            .rd_en   (commit & ~cur.we),
            .rd_zero (fault),
            .rd_byte (rdata[8*i +: 8])
        );
    end
endmodule
